// File: rtl/pc_pkg.sv
// Shared definitions for the program counter: the operation type selected
// each cycle and the fixed-priority decoder that picks it from the raw
// request lines.
package pc_pkg;

    // One operation is applied per clock; PC_HOLD keeps the current address.
    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_BRANCH,
        PC_JUMP,
        PC_CALL,
        PC_RET
    } pc_op_e;

    // Fixed priority: call > ret > jump > branch > increment > hold.
    // Builds without a return stack pass 1'b0 for call and ret.
    function automatic pc_op_e pc_decode(
        input logic call,
        input logic ret,
        input logic jump,
        input logic branch,
        input logic increment
    );
        pc_op_e op;
        if (call) begin
            op = PC_CALL;
        end else if (ret) begin
            op = PC_RET;
        end else if (jump) begin
            op = PC_JUMP;
        end else if (branch) begin
            op = PC_BRANCH;
        end else if (increment) begin
            op = PC_INC;
        end else begin
            op = PC_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/pc_return_stack.sv
// LIFO of return addresses, STACK_DEPTH entries of ADDR_WIDTH bits.
// A push while full and a pop while empty are ignored; the caller owns the
// error reporting. If push and pop arrive together, push wins.
module pc_return_stack #(
    parameter int ADDR_WIDTH  = 5,
    parameter int STACK_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] push_data,
    output logic [ADDR_WIDTH-1:0] top_data,
    output logic                  full,
    output logic                  empty
);

    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(STACK_DEPTH);

    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic [ADDR_WIDTH-1:0] mem_q [STACK_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_d [STACK_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    // The occupancy count is both the next free slot and one above the top.
    assign wr_ptr   = PTR_W'(count_q);
    assign rd_ptr   = PTR_W'(count_q - 1'b1);
    assign full     = (count_q == DEPTH_CNT);
    assign empty    = (count_q == '0);
    assign top_data = mem_q[rd_ptr];

    // Next occupancy and storage contents for the requested push or pop.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path leaves a value unassigned and no latch is inferred.
        count_d = count_q;
        mem_d   = mem_q;
        if (push && !full) begin
            mem_d[wr_ptr] = push_data;
            count_d       = count_q + 1'b1;
        end else if (pop && !empty) begin
            count_d = count_q - 1'b1;
        end
    end

    // Occupancy register; reset empties the stack.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: state is written with non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entry storage.
    // NOTE: the entries are deliberately not reset: an entry is only read
    // after it has been pushed, and clearing the count already empties the
    // stack, so a reset here would only add reset fan-out.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/program_counter.sv
// Program counter with increment, relative branch and absolute jump.
// Optional return stack (call/ret plus status outputs) is compiled in when
// the macro PC_CALL_STACK_EN is defined; without it STACK_DEPTH is unused.
module program_counter
    import pc_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 5,
    parameter int unsigned RESET_ADDR  = 0,
    parameter int          STACK_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  increment,
    input  logic                  branch,
    input  logic [ADDR_WIDTH-1:0] branch_offset,
    input  logic                  jump,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
`ifdef PC_CALL_STACK_EN
    input  logic                  call,
    input  logic                  ret,
    output logic                  stack_empty,
    output logic                  stack_full,
    output logic                  stack_err,
`endif
    output logic [ADDR_WIDTH-1:0] pc
);

    localparam logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_ADDR);

    pc_op_e                op;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic [ADDR_WIDTH-1:0] pc_plus_one;
    logic [ADDR_WIDTH-1:0] pc_branch;

    // Both sums wrap modulo 2^ADDR_WIDTH. Adding the offset at the full
    // address width is the same as adding its sign extension, so a negative
    // displacement needs no special handling. Branches are relative to the
    // current pc, not pc+1.
    assign pc_plus_one = pc_q + ADDR_WIDTH'(1);
    assign pc_branch   = pc_q + branch_offset;

`ifdef PC_CALL_STACK_EN
    logic                  stk_push;
    logic                  stk_pop;
    logic                  stk_full;
    logic                  stk_empty;
    logic [ADDR_WIDTH-1:0] stk_top;
    logic                  stack_err_q;
    logic                  stack_err_d;

    assign op = pc_decode(call, ret, jump, branch, increment);

    pc_return_stack #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clock     (clock),
        .reset     (reset),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc_plus_one),
        .top_data  (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // Stack side effects: a call on a full stack or a ret on an empty one
    // leaves the stack untouched and raises the error pulse instead.
    always_comb begin
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        stack_err_d = 1'b0;
        case (op)
            PC_CALL: begin
                stk_push    = !stk_full;
                stack_err_d = stk_full;
            end
            PC_RET: begin
                stk_pop     = !stk_empty;
                stack_err_d = stk_empty;
            end
            default: begin
            end
        endcase
    end

    // Error pulse register: high for the single cycle after the bad request,
    // aligned with the pc update that request caused.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stack_err_q <= 1'b0;
        end else begin
            stack_err_q <= stack_err_d;
        end
    end

    assign stack_err   = stack_err_q;
    assign stack_full  = stk_full;
    assign stack_empty = stk_empty;
`else
    // No return stack in this build: call and ret can never be requested.
    localparam int unused_stack_depth = STACK_DEPTH;

    assign op = pc_decode(1'b0, 1'b0, jump, branch, increment);
`endif

    // Next-address selection for the decoded operation.
    always_comb begin
        pc_d = pc_q;
        case (op)
            PC_INC:    pc_d = pc_plus_one;
            PC_BRANCH: pc_d = pc_branch;
            PC_JUMP:   pc_d = jump_addr;
`ifdef PC_CALL_STACK_EN
            // A call still jumps when the push had to be discarded.
            PC_CALL:   pc_d = jump_addr;
            // A ret with nothing to return to falls through like increment.
            PC_RET:    pc_d = stk_empty ? pc_plus_one : stk_top;
`endif
            default:   pc_d = pc_q;
        endcase
    end

    // Program-counter register; reset forces the start address at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter (ADDR_WIDTH=5, RESET_ADDR=0,
// STACK_DEPTH=4). Return-stack scenarios run when PC_CALL_STACK_EN is defined.
module tb_program_counter;

    localparam int AW    = 5;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic          err;
        logic          full;
        logic          empty;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          increment;
    logic          branch;
    logic [AW-1:0] branch_offset;
    logic          jump;
    logic [AW-1:0] jump_addr;
    logic [AW-1:0] pc;
`ifdef PC_CALL_STACK_EN
    logic          call;
    logic          ret;
    logic          stack_empty;
    logic          stack_full;
    logic          stack_err;
`endif

    exp_t          sb_q[$];
    string         tag_q[$];
    logic [AW-1:0] model_pc;
    logic [AW-1:0] model_stk[$];
    int            n_compared   = 0;
    int            n_mismatched = 0;

    program_counter #(
        .ADDR_WIDTH  (AW),
        .RESET_ADDR  (0),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .increment     (increment),
        .branch        (branch),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_addr     (jump_addr),
`ifdef PC_CALL_STACK_EN
        .call          (call),
        .ret           (ret),
        .stack_empty   (stack_empty),
        .stack_full    (stack_full),
        .stack_err     (stack_err),
`endif
        .pc            (pc)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic clear_inputs();
        increment     = 1'b0;
        branch        = 1'b0;
        branch_offset = '0;
        jump          = 1'b0;
        jump_addr     = '0;
`ifdef PC_CALL_STACK_EN
        call          = 1'b0;
        ret           = 1'b0;
`endif
    endtask

    task automatic model_reset();
        model_pc = '0;
        model_stk.delete();
    endtask

    // Drive one request set, push the model's prediction, clock once and
    // compare the DUT against the popped expectation.
    task automatic apply(input string tag, input logic c, input logic r, input logic j,
                         input logic b, input logic i, input logic [AW-1:0] off,
                         input logic [AW-1:0] addr);
        exp_t          e;
        string         t;
        logic [AW-1:0] nxt;
        logic [AW-1:0] plus1;
        logic          err;
        err           = 1'b0;
        plus1         = model_pc + 1'b1;
        increment     = i;
        branch        = b;
        branch_offset = off;
        jump          = j;
        jump_addr     = addr;
`ifdef PC_CALL_STACK_EN
        call = c;
        ret  = r;
        if (c) begin
            if (model_stk.size() < DEPTH) model_stk.push_back(plus1);
            else err = 1'b1;
            nxt = addr;
        end else if (r) begin
            if (model_stk.size() > 0) begin
                nxt = model_stk.pop_back();
            end else begin
                nxt = plus1;
                err = 1'b1;
            end
        end else
`endif
        if (j)      nxt = addr;
        else if (b) nxt = model_pc + off;
        else if (i) nxt = plus1;
        else        nxt = model_pc;
        model_pc = nxt;
        e.pc    = nxt;
        e.err   = err;
        e.full  = (model_stk.size() == DEPTH);
        e.empty = (model_stk.size() == 0);
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clock);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_underflow"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            check({t, "_pc"}, 32'(pc), 32'(e.pc));
`ifdef PC_CALL_STACK_EN
            check({t, "_err"}, 32'(stack_err), 32'(e.err));
            check({t, "_full"}, 32'(stack_full), 32'(e.full));
            check({t, "_empty"}, 32'(stack_empty), 32'(e.empty));
`endif
        end
        clear_inputs();
    endtask

    // Safety net: the bench only waits on the free-running clock, but never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic c, r, j, b, i;
        clear_inputs();
        model_reset();
        reset = 1'b1;
        #1;
        check("reset_pc", 32'(pc), 32'd0);
`ifdef PC_CALL_STACK_EN
        check("reset_empty", 32'(stack_empty), 32'd1);
        check("reset_full", 32'(stack_full), 32'd0);
        check("reset_err", 32'(stack_err), 32'd0);
`endif
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Count through the whole address space and wrap.
        for (int k = 0; k < 33; k++) begin
            apply("inc_wrap", 0, 0, 0, 0, 1, '0, '0);
            if (k == 30) check("inc_reach_31", 32'(pc), 32'd31);
            if (k == 31) check("inc_wrap_0", 32'(pc), 32'd0);
        end
        check("inc_end_1", 32'(pc), 32'd1);

        // Reset mid-cycle acts immediately and overrides a pending request.
        apply("jump_13", 0, 0, 1, 0, 0, '0, 5'd13);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_pc", 32'(pc), 32'd0);
        increment = 1'b1;
        @(posedge clock);
        #1;
        check("reset_override", 32'(pc), 32'd0);
        reset = 1'b0;
        clear_inputs();
        model_reset();
        apply("post_reset_inc", 0, 0, 0, 0, 1, '0, '0);

        // Relative branches in both directions, wrapping at the edges.
        apply("jump_3", 0, 0, 1, 0, 0, '0, 5'd3);
        apply("branch_neg4", 0, 0, 0, 1, 0, 5'b11100, '0);
        check("branch_neg_31", 32'(pc), 32'd31);
        apply("jump_30", 0, 0, 1, 0, 0, '0, 5'd30);
        apply("branch_pos5", 0, 0, 0, 1, 0, 5'd5, '0);
        check("branch_pos_3", 32'(pc), 32'd3);

        // Priority among simultaneous requests, then hold.
        apply("prio_jump", 0, 0, 1, 1, 1, 5'd7, 5'd17);
        check("prio_jump_17", 32'(pc), 32'd17);
        apply("prio_branch", 0, 0, 0, 1, 1, 5'd2, '0);
        check("prio_branch_19", 32'(pc), 32'd19);
        apply("hold", 0, 0, 0, 0, 0, '0, '0);
        check("hold_19", 32'(pc), 32'd19);

`ifdef PC_CALL_STACK_EN
        // Call / return, then return on an empty stack.
        apply("jump_4", 0, 0, 1, 0, 0, '0, 5'd4);
        apply("call_20", 1, 0, 0, 0, 0, '0, 5'd20);
        check("call_20_pc", 32'(pc), 32'd20);
        apply("ret_5", 0, 1, 0, 0, 0, '0, '0);
        check("ret_5_pc", 32'(pc), 32'd5);
        apply("ret_empty", 0, 1, 0, 0, 0, '0, '0);
        check("ret_empty_pc", 32'(pc), 32'd6);
        check("ret_empty_err", 32'(stack_err), 32'd1);
        apply("err_clears", 0, 0, 0, 0, 0, '0, '0);

        // Fill the stack, overflow once, unwind in LIFO order.
        apply("jump_8", 0, 0, 1, 0, 0, '0, 5'd8);
        for (int k = 0; k < 5; k++) begin
            apply("call_fill", 1, 0, 0, 0, 0, '0, AW'(10 + k));
            if (k == 3) check("full_after_4", 32'(stack_full), 32'd1);
        end
        check("overflow_target", 32'(pc), 32'd14);
        check("overflow_err", 32'(stack_err), 32'd1);
        for (int k = 0; k < 4; k++) apply("ret_unwind", 0, 1, 0, 0, 0, '0, '0);
        check("unwind_end_9", 32'(pc), 32'd9);
`endif

        // Random mix of requests against the model.
        for (int k = 0; k < 120; k++) begin
            c = 1'b0;
            r = 1'b0;
`ifdef PC_CALL_STACK_EN
            c = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 6) == 0);
`endif
            j = ($urandom_range(0, 5) == 0);
            b = ($urandom_range(0, 3) == 0);
            i = ($urandom_range(0, 1) == 0);
            apply("random", c, r, j, b, i, AW'($urandom), AW'($urandom));
        end

        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
